// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and drain controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Produces operand forwarding selects, stall/bubble/flush controls, a halt drain sequence and status.
module pipe_hazard_ctrl #(
    parameter int AW           = 4,
    parameter int ZERO_REG     = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_halt,
    input  logic [AW-1:0]    id_src0_addr,
    input  logic [AW-1:0]    id_src1_addr,
    input  logic             id_src0_used,
    input  logic             id_src1_used,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_dst,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic             mem_is_load,
    input  logic [AW-1:0]    mem_dst,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_valid,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_dst,
    input  logic             redirect,
    output logic [1:0]       fwd_sel0,
    output logic [1:0]       fwd_sel1,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t         state, next_state;
    logic [DCW-1:0] drain_cnt;
    logic [WCW-1:0] wait_cnt;

    logic src0_ok, src1_ok;
    logic ex_hit0, mem_hit0, wb_hit0;
    logic ex_hit1, mem_hit1, wb_hit1;
    logic lu, ms;

    // A load in MEM forwards like any other result; the datapath substitutes the load data.
    logic unused_mem_is_load;
    assign unused_mem_is_load = mem_is_load;

    assign src0_ok = id_src0_used && !((ZERO_REG != 0) && (id_src0_addr == '0));
    assign src1_ok = id_src1_used && !((ZERO_REG != 0) && (id_src1_addr == '0));

    assign ex_hit0  = src0_ok && ex_valid  && ex_we  && (ex_dst  == id_src0_addr);
    assign mem_hit0 = src0_ok && mem_valid && mem_we && (mem_dst == id_src0_addr);
    assign wb_hit0  = src0_ok && wb_valid  && wb_we  && (wb_dst  == id_src0_addr);
    assign ex_hit1  = src1_ok && ex_valid  && ex_we  && (ex_dst  == id_src1_addr);
    assign mem_hit1 = src1_ok && mem_valid && mem_we && (mem_dst == id_src1_addr);
    assign wb_hit1  = src1_ok && wb_valid  && wb_we  && (wb_dst  == id_src1_addr);

    assign lu = id_valid && ex_valid && ex_is_load && ex_we && (ex_hit0 || ex_hit1);
    assign ms = mem_req && !mem_ready;

    assign halted = (state == HALTED);

    always_comb begin
        fwd_sel0     = 2'd0;
        fwd_sel1     = 2'd0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        bubble_ex    = 1'b0;
        bubble_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        next_state   = state;
        if (!rst) begin
            if (ex_hit0)       fwd_sel0 = 2'd1;
            else if (mem_hit0) fwd_sel0 = 2'd2;
            else if (wb_hit0)  fwd_sel0 = 2'd3;
            if (ex_hit1)       fwd_sel1 = 2'd1;
            else if (mem_hit1) fwd_sel1 = 2'd2;
            else if (wb_hit1)  fwd_sel1 = 2'd3;
            case (state)
                RUN: begin
                    if (ms) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        bubble_wb    = 1'b1;
                    end else if (redirect) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (lu) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (id_valid && id_halt) begin
                        next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    if (ms) begin
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        bubble_wb    = 1'b1;
                    end else if (drain_cnt == '0) begin
                        next_state = HALTED;
                    end
                end
                HALTED: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == RUN && next_state == DRAIN)
                drain_cnt <= DCW'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && !ms && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
            // wait_cnt parks at its terminal value; mem_err is sticky anyway.
            if (!ms)
                wait_cnt <= '0;
            else if (wait_cnt != WCW'(MEM_TIMEOUT - 1))
                wait_cnt <= wait_cnt + 1'b1;
            if (ms && wait_cnt == WCW'(MEM_TIMEOUT - 1))
                mem_err <= 1'b1;
            if (state == RUN && stall_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, memory stall/timeout,
// redirect arbitration, halt drain and reset, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_halt, id_src0_used, id_src1_used;
    logic [3:0] id_src0_addr, id_src1_addr;
    logic       ex_valid, ex_we, ex_is_load;
    logic [3:0] ex_dst;
    logic       mem_valid, mem_we, mem_is_load;
    logic [3:0] mem_dst;
    logic       mem_req, mem_ready;
    logic       wb_valid, wb_we;
    logic [3:0] wb_dst;
    logic       redirect;
    logic [1:0] fwd_sel0, fwd_sel1;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       bubble_ex, bubble_wb, flush_if_id, flush_id_ex;
    logic       halted, mem_err;
    logic [3:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_hazard_ctrl #(
        .AW(4), .ZERO_REG(1), .DRAIN_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_halt(id_halt),
        .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
        .id_src0_used(id_src0_used), .id_src1_used(id_src1_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_dst(mem_dst),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst),
        .redirect(redirect),
        .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_halt = 0; id_src0_used = 0; id_src1_used = 0;
        id_src0_addr = 0; id_src1_addr = 0;
        ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_dst = 0;
        mem_valid = 0; mem_we = 0; mem_is_load = 0; mem_dst = 0;
        mem_req = 0; mem_ready = 0;
        wb_valid = 0; wb_we = 0; wb_dst = 0;
        redirect = 0;
    endtask

    function automatic logic [7:0] stalls();
        return {4'b0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem};
    endfunction

    function automatic logic [7:0] bfl();
        return {4'b0, bubble_ex, bubble_wb, flush_if_id, flush_id_ex};
    endfunction

    task automatic set_load_use(input logic [3:0] r);
        id_valid = 1; id_src1_used = 1; id_src1_addr = r;
        ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dst = r;
    endtask

    initial begin
        idle();
        rst = 1;
        // Reset with stall, redirect and forwarding conditions all present.
        mem_req = 1; redirect = 1; set_load_use(4'd3);
        #2;
        chk("rst_stalls", stalls(), 8'h0);
        chk("rst_bfl", bfl(), 8'h0);
        chk("rst_fwd1", {6'b0, fwd_sel1}, 8'h0);
        tick(); tick();
        rst = 0; idle();
        #1;
        chk("post_rst_halted", {7'b0, halted}, 8'h0);
        chk("post_rst_mem_err", {7'b0, mem_err}, 8'h0);
        chk("post_rst_cnt", {4'b0, stall_cnt}, 8'h0);
        chk("post_rst_stalls", stalls(), 8'h0);

        // Load-use on r3 via src1
        tick(); set_load_use(4'd3); #1;
        chk("lu_stalls", stalls(), 8'hC);
        chk("lu_bfl", bfl(), 8'h8);
        chk("lu_fwd1", {6'b0, fwd_sel1}, 8'h1);
        tick();
        ex_valid = 0; ex_we = 0; ex_is_load = 0;
        mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_dst = 4'd3;
        #1;
        chk("lu_after_stalls", stalls(), 8'h0);
        chk("lu_after_bfl", bfl(), 8'h0);
        chk("lu_after_fwd1", {6'b0, fwd_sel1}, 8'h2);
        chk("lu_cnt", {4'b0, stall_cnt}, 8'h1);

        // Same load writing r0: no hazard, no forward
        tick(); idle(); set_load_use(4'd0); #1;
        chk("lu_r0_stalls", stalls(), 8'h0);
        chk("lu_r0_fwd1", {6'b0, fwd_sel1}, 8'h0);

        // Forward priority on r5
        tick(); idle();
        id_valid = 1; id_src0_used = 1; id_src0_addr = 4'd5;
        ex_valid = 1; ex_we = 1; ex_dst = 4'd5;
        mem_valid = 1; mem_we = 1; mem_dst = 4'd5;
        wb_valid = 1; wb_we = 1; wb_dst = 4'd5;
        #1;
        chk("fwd_ex", {6'b0, fwd_sel0}, 8'h1);
        chk("fwd_ex_nostall", stalls(), 8'h0);
        ex_valid = 0; #1;
        chk("fwd_mem", {6'b0, fwd_sel0}, 8'h2);
        mem_we = 0; #1;
        chk("fwd_wb", {6'b0, fwd_sel0}, 8'h3);
        id_src0_used = 0; #1;
        chk("fwd_unused", {6'b0, fwd_sel0}, 8'h0);

        // Memory stall for 4 cycles, MEM_TIMEOUT = 4
        tick(); idle();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ms_stalls", stalls(), 8'hF);
            chk("ms_bfl", bfl(), 8'h4);
            chk("ms_err_early", {7'b0, mem_err}, 8'h0);
            tick();
        end
        chk("ms_err_set", {7'b0, mem_err}, 8'h1);
        chk("ms_cnt", {4'b0, stall_cnt}, 8'h5);
        mem_ready = 1; #1;
        chk("ms_done_stalls", stalls(), 8'h0);
        tick(); idle(); #1;
        chk("ms_err_sticky", {7'b0, mem_err}, 8'h1);

        // Redirect together with load-use
        set_load_use(4'd7); redirect = 1; #1;
        chk("rd_lu_stalls", stalls(), 8'h0);
        chk("rd_lu_bfl", bfl(), 8'h3);
        tick(); idle(); #1;
        chk("rd_lu_cnt", {4'b0, stall_cnt}, 8'h5);

        // Redirect together with a memory stall
        redirect = 1; mem_req = 1; mem_ready = 0; #1;
        chk("rd_ms_bfl", bfl(), 8'h4);
        chk("rd_ms_stalls", stalls(), 8'hF);
        tick();
        mem_ready = 1; #1;
        chk("rd_ms_release_bfl", bfl(), 8'h3);
        tick(); idle(); #1;
        chk("rd_ms_cnt", {4'b0, stall_cnt}, 8'h6);

        // Saturation of the 4-bit stall counter
        mem_req = 1;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_at_max", {4'b0, stall_cnt}, 8'hF);
        tick();
        chk("sat_hold", {4'b0, stall_cnt}, 8'hF);
        idle(); tick();

        // Halt drain with one memory stall cycle inside
        id_valid = 1; id_halt = 1; #1;
        chk("hlt_run_stalls", stalls(), 8'h0);
        tick();
        redirect = 1; #1;
        chk("drain1_stalls", stalls(), 8'hC);
        chk("drain1_bfl", bfl(), 8'h0);
        chk("drain1_halted", {7'b0, halted}, 8'h0);
        tick();
        redirect = 0; mem_req = 1; mem_ready = 0; #1;
        chk("drain2_ms_stalls", stalls(), 8'hF);
        chk("drain2_ms_bfl", bfl(), 8'h4);
        tick();
        mem_req = 0; #1;
        chk("drain3_stalls", stalls(), 8'hC);
        tick(); #1;
        chk("drain4_halted", {7'b0, halted}, 8'h0);
        tick();
        redirect = 1; #1;
        chk("halted_5th", {7'b0, halted}, 8'h1);
        chk("halted_stalls", stalls(), 8'hF);
        chk("halted_bfl", bfl(), 8'h0);
        tick(); tick(); #1;
        chk("halted_hold", {7'b0, halted}, 8'h1);
        chk("halted_hold_stalls", stalls(), 8'hF);

        // Reset out of HALTED, then reset mid-drain
        rst = 1; idle(); tick();
        rst = 0; #1;
        chk("rst_halt_exit", {7'b0, halted}, 8'h0);
        id_valid = 1; id_halt = 1;
        tick(); #1;
        chk("drain_again_stalls", stalls(), 8'hC);
        rst = 1; #1;
        chk("rst_mid_stalls", stalls(), 8'h0);
        tick();
        rst = 0; idle(); #1;
        chk("rst_mid_halted", {7'b0, halted}, 8'h0);
        chk("rst_mid_stalls_after", stalls(), 8'h0);
        chk("rst_mid_bfl", bfl(), 8'h0);
        chk("rst_mid_cnt", {4'b0, stall_cnt}, 8'h0);
        chk("rst_mid_err", {7'b0, mem_err}, 8'h0);
        set_load_use(4'd2); #1;
        chk("rst_mid_run_lu", stalls(), 8'hC);
        tick(); idle(); #1;
        chk("rst_mid_cnt_run", {4'b0, stall_cnt}, 8'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and drain controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It replaces the fixed stall/forward logic with a single block. The block adds:
- ID-stage operand forwarding selects.
- Load-use bubbles.
- Variable-latency memory stalls through a ready handshake.
- Branch/jump flush arbitration.
- A halt drain state machine.
- A memory-timeout flag and a stall performance counter.

Parameters:
AW, 4, register address width (2**AW architectural registers)
ZERO_REG, 1, 1 = register address 0 is hardwired zero; it never hazards and never forwards
DRAIN_CYCLES, 3, cycles needed for the stages behind ID to retire after halt leaves ID
MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_err is set
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
id_valid  in  1  ID holds a live instruction
id_halt  in  1  ID instruction is HLT
id_src0_addr, id_src1_addr  in  AW  ID source register addresses
id_src0_used, id_src1_used  in  1  source is actually read by the instruction
ex_valid, ex_we, ex_is_load  in  1  EX-stage instruction status
ex_dst  in  AW  EX destination register
mem_valid, mem_we, mem_is_load  in  1  MEM-stage instruction status
mem_dst  in  AW  MEM destination register
mem_req  in  1  MEM stage has an outstanding data-memory access
mem_ready  in  1  data memory completes the access this cycle
wb_valid, wb_we  in  1  WB-stage instruction status
wb_dst  in  AW  WB destination register
redirect  in  1  taken branch/jump resolved in EX
fwd_sel0, fwd_sel1  out  2  operand source: 0 = register file, 1 = EX, 2 = MEM, 3 = WB
stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the PC or pipeline register
bubble_ex  out  1  load a NOP into ID/EX
bubble_wb  out  1  load a NOP into MEM/WB
flush_if_id, flush_id_ex  out  1  kill the younger instructions
halted  out  1  pipeline fully drained and stopped
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  saturating count of front-end stall cycles

Behaviour:
Reset:
- Synchronous reset gives state = RUN, drain_cnt = 0, wait_cnt = 0, halted = 0, mem_err = 0, stall_cnt = 0.
- While rst = 1, every stall, bubble and flush output is 0 and fwd_sel0 = fwd_sel1 = 0.

Forwarding (combinational, per source n):
- A stage matches when it is valid, its we = 1, its dst equals src_n, and src_n_used = 1.
- Priority is youngest first: EX (1), then MEM (2), then WB (3), otherwise 0.
- When ZERO_REG = 1 and src_n = 0, the select is always 0.
- A MEM match with mem_is_load = 1 still gives 2; the datapath substitutes load data.

Load-use hazard (lu):
- lu = id_valid AND ex_valid AND ex_is_load AND ex_we AND (an EX match on any used source).
- Result: stall_pc = 1, stall_if_id = 1, bubble_ex = 1 for exactly one cycle per occurrence.

Memory stall (ms):
- ms = mem_req AND NOT mem_ready.
- Result: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem = 1, and bubble_wb = 1.
- Memory stall overrides the load-use hazard, so bubble_ex = 0 during ms.

Redirect:
- When redirect = 1 and ms = 0: flush_if_id = 1 and flush_id_ex = 1.
- Redirect overrides lu: stall_pc = 0 so the new target loads, and bubble_ex = 0.
- When redirect = 1 and ms = 1: no flush. EX stays frozen and re-presents redirect after ms clears.

Halt state machine:
- RUN: normal operation.
  - RUN to DRAIN when id_valid AND id_halt AND NOT redirect AND NOT ms AND NOT lu.
  - On that transition, drain_cnt is set to DRAIN_CYCLES - 1.
- DRAIN:
  - stall_pc = 1 and stall_if_id = 1.
  - The halt advances down the pipe as a NOP.
  - redirect is ignored: no flush is issued.
  - drain_cnt decrements only in cycles where ms = 0.
  - When drain_cnt = 0 and ms = 0, the next state is HALTED.
- HALTED:
  - halted = 1.
  - All four stall outputs = 1; bubble and flush outputs = 0.
  - Only rst leaves this state.

Memory timeout:
- wait_cnt increments in every ms cycle and clears when ms = 0.
- When wait_cnt reaches MEM_TIMEOUT - 1 while ms = 1, mem_err is set.
- mem_err stays set until rst; the stall itself continues.

Stall counter:
- stall_cnt increments in each RUN-state cycle with stall_pc = 1.
- It saturates at all-ones.

Test Plan:
- Load-use: EX is a load writing r3 and ID reads r3 as src1. Expect one cycle of stall_pc = stall_if_id = bubble_ex = 1, then fwd_sel1 = 2 on the next cycle. If the same load writes r0 instead, expect no stall.
- Forward priority: EX, MEM and WB all write r5 and ID reads r5. Expect fwd_sel0 = 1. With EX invalid, expect 2.
- Memory stall: assert mem_req with mem_ready low for 4 cycles. Expect stall_pc through stall_ex_mem = 1 and bubble_wb = 1 for 4 cycles, and stall_cnt to increase by 4. With MEM_TIMEOUT = 4, expect mem_err = 1 after the 4th cycle.
- Redirect versus stall:
  - redirect together with lu: expect flush_if_id = flush_id_ex = 1 and bubble_ex = 0.
  - redirect together with ms: expect no flush until mem_ready, then a flush in the following cycle.
- Halt drain: HLT in ID with DRAIN_CYCLES = 3, with one ms cycle injected during the drain. Expect halted = 1 on the 5th cycle after entering DRAIN, with all stalls held afterwards.
- Reset mid-drain: assert rst during DRAIN. Expect the next cycle state = RUN, halted = 0, all outputs 0, and stall_cnt = 0.
